load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-request load/store unit: 32-bit address generation, alignment check, lane handling and extension.
// Latency: accept -> ACCESS -> RESP (2 cycles). Only one request in flight; req_ready low until the response is consumed.
module load_store_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_load_data,
    output logic        resp_error,
    output logic [31:0] address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    output logic        store_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        err_q, err_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] eff_addr;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [3:0]  lane_mask;

    always_comb begin
        eff_addr = req_base + req_offset;
        case (req_funct3)
            3'd0:    req_err = 1'b0;
            3'd1:    req_err = eff_addr[0];
            3'd2:    req_err = (eff_addr[1:0] != 2'b00);
            3'd4:    req_err = req_is_store;
            3'd5:    req_err = req_is_store | eff_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        byte_lane = mem_read_data[{address_q[1:0], 3'b000} +: 8];
        half_lane = address_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'd0:    load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'd1:    load_ext = {{16{half_lane[15]}}, half_lane};
            3'd2:    load_ext = mem_read_data;
            3'd4:    load_ext = {24'd0, byte_lane};
            3'd5:    load_ext = {16'd0, half_lane};
            default: load_ext = 32'd0;
        endcase
    end

    // Gating with reset_n keeps a reset landing in ACCESS from committing the write.
    always_comb begin
        case (funct3_q)
            3'd0:    lane_mask = 4'b0001 << address_q[1:0];
            3'd1:    lane_mask = 4'b0011 << address_q[1:0];
            3'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        store_enable     = reset_n & (state_q == ACCESS) & is_store_q & ~err_q;
        mem_write_enable = store_enable ? lane_mask : 4'b0000;
    end

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        err_d       = err_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = ACCESS;
                    address_d  = eff_addr;
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    err_d      = req_err;
                    case (req_funct3[1:0])
                        2'd0:    wdata_d = {4{req_store_data[7:0]}};
                        2'd1:    wdata_d = {2{req_store_data[15:0]}};
                        default: wdata_d = req_store_data;
                    endcase
                end
            end
            ACCESS: begin
                state_d     = RESP;
                resp_err_d  = err_q;
                resp_data_d = (err_q | is_store_q) ? 32'd0 : load_ext;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            address_q   <= 32'd0;
            wdata_q     <= 32'd0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            err_q       <= 1'b0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            err_q       <= err_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_load_data = resp_data_q;
    assign resp_error     = resp_err_q;
    assign address        = address_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word byte-enabled memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_store_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_load_data;
    logic        resp_error;
    logic [31:0] address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic        store_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    logic        mem_init;
    int          checks = 0;
    int          errors = 0;

    load_store_unit dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_base         (req_base),
        .req_offset       (req_offset),
        .req_store_data   (req_store_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_load_data   (resp_load_data),
        .resp_error       (resp_error),
        .address          (address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .store_enable     (store_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    // Word i is preloaded with 0xA5A5_00ii so untouched words are recognisable.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | i;
        end else if (store_enable) begin
            for (int b = 0; b < 4; b++)
                if (mem_write_enable[b]) mem[address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
    end

    assign mem_read_data = mem[address[7:2]];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request in IDLE; returns one cycle later, in ACCESS.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sd);
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_base       = base;
        req_offset     = off;
        req_store_data = sd;
        tick();
        req_valid      = 1'b0;
    endtask

    // From ACCESS: checks the response and the return to IDLE (resp_ready held high).
    task automatic finish(input string tag, input logic [31:0] exp_data, input logic exp_err);
        chk({tag, "_access_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        tick();
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_resp_data"}, resp_load_data, exp_data);
        chk({tag, "_resp_error"}, {31'd0, resp_error}, {31'd0, exp_err});
        chk({tag, "_resp_no_store"}, {27'd0, store_enable, mem_write_enable}, 32'd0);
        tick();
        chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset_n        = 1'b0;
        mem_init       = 1'b1;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_funct3     = 3'd0;
        req_base       = 32'd0;
        req_offset     = 32'd0;
        req_store_data = 32'd0;
        resp_ready     = 1'b1;
        tick();
        tick();
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_resp_data", resp_load_data, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        chk("rst_we", {27'd0, store_enable, mem_write_enable}, 32'd0);
        mem_init = 1'b0;
        reset_n  = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // SW 0xDEADBEEF to 0x10+4
        issue(1'b1, 3'd2, 32'h10, 32'h4, 32'hDEAD_BEEF);
        chk("sw_store_enable", {31'd0, store_enable}, 32'd1);
        chk("sw_we", {28'd0, mem_write_enable}, 32'hF);
        chk("sw_address", address, 32'h14);
        chk("sw_wdata", mem_write_data, 32'hDEAD_BEEF);
        chk("sw_req_ready", {31'd0, req_ready}, 32'd0);
        finish("sw", 32'd0, 1'b0);
        chk("sw_mem", mem[5], 32'hDEAD_BEEF);
        issue(1'b0, 3'd2, 32'h14, 32'h0, 32'd0);
        chk("lw14_no_store", {31'd0, store_enable}, 32'd0);
        finish("lw14", 32'hDEAD_BEEF, 1'b0);

        // SB 0x80 to 0x21, then LB/LBU
        issue(1'b1, 3'd0, 32'h20, 32'h1, 32'h1234_5680);
        chk("sb_we", {28'd0, mem_write_enable}, 32'h2);
        chk("sb_wdata", mem_write_data, 32'h8080_8080);
        finish("sb", 32'd0, 1'b0);
        chk("sb_mem", mem[8], 32'hA5A5_8008);
        issue(1'b0, 3'd0, 32'h21, 32'h0, 32'd0);
        finish("lb", 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 3'd4, 32'h21, 32'h0, 32'd0);
        finish("lbu", 32'h0000_0080, 1'b0);
        issue(1'b0, 3'd0, 32'h20, 32'h0, 32'd0);
        finish("lb_pos", 32'h0000_0008, 1'b0);

        // SH 0x8001 to 0x22, then LH/LHU
        issue(1'b1, 3'd1, 32'h22, 32'h0, 32'hFFFF_8001);
        chk("sh_we", {28'd0, mem_write_enable}, 32'hC);
        chk("sh_wdata", mem_write_data, 32'h8001_8001);
        finish("sh", 32'd0, 1'b0);
        chk("sh_mem", mem[8], 32'h8001_8008);
        issue(1'b0, 3'd1, 32'h22, 32'h0, 32'd0);
        finish("lh", 32'hFFFF_8001, 1'b0);
        issue(1'b0, 3'd5, 32'h20, 32'h2, 32'd0);
        finish("lhu", 32'h0000_8001, 1'b0);

        // Error cases
        issue(1'b0, 3'd2, 32'h13, 32'h0, 32'd0);
        chk("lw13_no_store", {27'd0, store_enable, mem_write_enable}, 32'd0);
        finish("lw13", 32'd0, 1'b1);
        issue(1'b1, 3'd1, 32'h25, 32'h0, 32'h0000_BEEF);
        chk("sh25_no_store", {27'd0, store_enable, mem_write_enable}, 32'd0);
        finish("sh25", 32'd0, 1'b1);
        chk("sh25_mem", mem[9], 32'hA5A5_0009);
        issue(1'b1, 3'd3, 32'h28, 32'h0, 32'h1111_2222);
        chk("f3_no_store", {27'd0, store_enable, mem_write_enable}, 32'd0);
        finish("f3", 32'd0, 1'b1);
        chk("f3_mem", mem[10], 32'hA5A5_000A);
        issue(1'b1, 3'd4, 32'h2C, 32'h0, 32'h1111_2222);
        chk("sbu_no_store", {27'd0, store_enable, mem_write_enable}, 32'd0);
        finish("sbu", 32'd0, 1'b1);

        // Wrap-around
        issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'd0);
        chk("wrap_address", address, 32'h0);
        finish("wrap", 32'hA5A5_0000, 1'b0);
        issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h2, 32'd0);
        finish("wrap_mis", 32'd0, 1'b1);

        // Backpressure
        resp_ready = 1'b0;
        issue(1'b0, 3'd2, 32'h14, 32'h0, 32'd0);
        tick();
        chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_data", resp_load_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            req_valid      = i[0] ? 1'b0 : 1'b1;
            req_is_store   = 1'b1;
            req_funct3     = 3'd2;
            req_base       = 32'h40;
            req_offset     = 32'h0;
            req_store_data = 32'h0BAD_0BAD;
            tick();
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_data", resp_load_data, 32'hDEAD_BEEF);
            chk("bp_hold_error", {31'd0, resp_error}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_no_store", {31'd0, store_enable}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_mem40", mem[16], 32'hA5A5_0010);

        // Reset during ACCESS of SW 0x55555555 to 0x30
        issue(1'b1, 3'd2, 32'h30, 32'h0, 32'h5555_5555);
        reset_n = 1'b0;
        #1;
        chk("racc_store_enable", {31'd0, store_enable}, 32'd0);
        chk("racc_we", {28'd0, mem_write_enable}, 32'd0);
        tick();
        chk("racc_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("racc_resp_error", {31'd0, resp_error}, 32'd0);
        chk("racc_resp_data", resp_load_data, 32'd0);
        chk("racc_address", address, 32'd0);
        chk("racc_wdata", mem_write_data, 32'd0);
        chk("racc_mem", mem[12], 32'hA5A5_000C);
        reset_n = 1'b1;
        #1;
        chk("racc_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 3'd2, 32'h30, 32'h0, 32'd0);
        finish("racc_lw", 32'hA5A5_000C, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
